// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration-time width helpers for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        DONE    = 2'd2
    } rst_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Never returns less than 1 so it can size a vector directly.
    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Async-clear, sync-set shift chain: brings board reset release into the clk domain.
module reset_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic asyncrst_n,
    output logic sync_n
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) chain <= '0;
        else             chain <= {chain[STAGES-2:0], 1'b1};
    end

    assign sync_n = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset controller: synchronised release, minimum-width stretch, then staged ordered
// release of NUM_RST active-low resets (bit 0 first); sw_rst_req re-runs the sequence.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned NUM_RST        = 4,
    parameter int unsigned STRETCH_CYCLES = 16,
    parameter int unsigned STEP_CYCLES    = 8
) (
    input  logic               clk,
    input  logic               asyncrst_n,
    input  logic               sw_rst_req,
    output logic [NUM_RST-1:0] rst_n_out,
    output logic               rst_done,
    output logic               busy
);

    localparam int unsigned CW = clog2_u(max_u(STRETCH_CYCLES, STEP_CYCLES) + 1);
    localparam int unsigned IW = clog2_u(NUM_RST + 1);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST    = CW'(STEP_CYCLES - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_RST - 1);

    if (SYNC_STAGES < 2)    begin : g_bad_sync    $error("SYNC_STAGES must be >= 2");    end
    if (NUM_RST < 1)        begin : g_bad_num     $error("NUM_RST must be >= 1");        end
    if (STRETCH_CYCLES < 1) begin : g_bad_stretch $error("STRETCH_CYCLES must be >= 1"); end
    if (STEP_CYCLES < 1)    begin : g_bad_step    $error("STEP_CYCLES must be >= 1");    end

    logic sync_n;

    reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .asyncrst_n (asyncrst_n),
        .sync_n     (sync_n)
    );

    rst_state_e         state_q, state_n;
    logic [CW-1:0]      cnt_q, cnt_n;
    logic [IW-1:0]      idx_q, idx_n;
    logic [NUM_RST-1:0] rst_q, rst_n;
    logic               done_q, done_n;
    logic               busy_q, busy_n;

    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            rst_q   <= rst_n;
            done_q  <= done_n;
            busy_q  <= busy_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        rst_n   = rst_q;
        done_n  = done_q;
        busy_n  = busy_q;

        // A software request wins over any release step scheduled on the same edge.
        if (sw_rst_req) begin
            state_n = HOLD;
            cnt_n   = '0;
            idx_n   = '0;
            rst_n   = '0;
            done_n  = 1'b0;
            busy_n  = 1'b1;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (!sync_n) begin
                        cnt_n = '0;
                    end else if (cnt_q == STRETCH_LAST) begin
                        rst_n[0] = 1'b1;
                        cnt_n    = '0;
                        idx_n    = '0;
                        if (NUM_RST == 1) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                        end else begin
                            state_n = RELEASE;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        idx_n = idx_q + 1'b1;
                        cnt_n = '0;
                        for (int unsigned i = 1; i < NUM_RST; i++) begin
                            if (idx_n == IW'(i)) rst_n[i] = 1'b1;
                        end
                        if (idx_n == LAST_IDX) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_n = HOLD;
                    cnt_n   = '0;
                    idx_n   = '0;
                    rst_n   = '0;
                    done_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            endcase
        end
    end

    assign rst_n_out = rst_q;
    assign rst_done  = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release-timing table plus async/sw reset corner cases.
module tb_reset_sequencer;

    logic       clk;
    logic       asyncrst_n;
    logic       sw_rst_req;
    logic [3:0] rst_n_out;
    logic       rst_done;
    logic       busy;

    logic       arst2_n;
    logic       req2;
    logic [0:0] rst_n_out_p;
    logic       rst_done_p;
    logic       busy_p;

    reset_sequencer dut (
        .clk        (clk),
        .asyncrst_n (asyncrst_n),
        .sw_rst_req (sw_rst_req),
        .rst_n_out  (rst_n_out),
        .rst_done   (rst_done),
        .busy       (busy)
    );

    reset_sequencer #(
        .SYNC_STAGES    (3),
        .NUM_RST        (1),
        .STRETCH_CYCLES (1),
        .STEP_CYCLES    (1)
    ) dut_p (
        .clk        (clk),
        .asyncrst_n (arst2_n),
        .sw_rst_req (req2),
        .rst_n_out  (rst_n_out_p),
        .rst_done   (rst_done_p),
        .busy       (busy_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Offsets are relative to the edge that releases bit 0; exp = {rst_n_out, rst_done, busy}.
    typedef struct {
        int         off;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[9];
    int   errors;
    int   checks;
    int   ecnt;

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got rst=%b done=%b busy=%b, want rst=%b done=%b busy=%b",
                     name, ecnt, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic chk_p(input string name, input logic [2:0] exp);
        checks++;
        if ({rst_n_out_p, rst_done_p, busy_p} !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got {rst,done,busy}=%b, want %b",
                     name, ecnt, {rst_n_out_p, rst_done_p, busy_p}, exp);
        end
    endtask

    task automatic goto_edge(input int target);
        while (ecnt < target) begin
            @(posedge clk);
            ecnt++;
        end
        #1;
    endtask

    task automatic run_table(input string name, input int b0);
        for (int i = 0; i < 9; i++) begin
            goto_edge(b0 + tbl[i].off);
            chk(name, {rst_n_out, rst_done, busy}, tbl[i].exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        ecnt   = 0;
        tbl[0] = '{-1, 6'b0000_01};
        tbl[1] = '{ 0, 6'b0001_01};
        tbl[2] = '{ 7, 6'b0001_01};
        tbl[3] = '{ 8, 6'b0011_01};
        tbl[4] = '{15, 6'b0011_01};
        tbl[5] = '{16, 6'b0111_01};
        tbl[6] = '{23, 6'b0111_01};
        tbl[7] = '{24, 6'b1111_10};
        tbl[8] = '{30, 6'b1111_10};

        asyncrst_n = 1'b0;
        sw_rst_req = 1'b0;
        arst2_n    = 1'b0;
        req2       = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        chk("reset_state", {rst_n_out, rst_done, busy}, 6'b0000_01);
        chk_p("reset_state_p", 3'b001);

        // Minimal-parameter instance: release lands on edge SYNC_STAGES+STRETCH = 4.
        arst2_n = 1'b1;
        ecnt    = 0;
        goto_edge(3);
        chk_p("param_edge3", 3'b001);
        goto_edge(4);
        chk_p("param_edge4", 3'b110);

        asyncrst_n = 1'b1;
        ecnt       = 0;
        run_table("power_on", 18);

        // Async pulse between edges while in DONE.
        #1 asyncrst_n = 1'b0;
        #1 chk("async_pulse", {rst_n_out, rst_done, busy}, 6'b0000_01);
        #1 asyncrst_n = 1'b1;
        ecnt = 0;
        run_table("replay", 18);

        // Software request held for three edges in DONE.
        sw_rst_req = 1'b1;
        goto_edge(ecnt + 1);
        chk("sw_first_edge", {rst_n_out, rst_done, busy}, 6'b0000_01);
        goto_edge(ecnt + 2);
        sw_rst_req = 1'b0;
        run_table("sw_req", ecnt + 16);

        // Software request on the edge that would release bit 2.
        asyncrst_n = 1'b0;
        #2 asyncrst_n = 1'b1;
        ecnt = 0;
        goto_edge(33);
        chk("pre_bit2", {rst_n_out, rst_done, busy}, 6'b0011_01);
        sw_rst_req = 1'b1;
        goto_edge(34);
        chk("sw_vs_bit2", {rst_n_out, rst_done, busy}, 6'b0000_01);
        sw_rst_req = 1'b0;
        run_table("after_bit2", 50);

        // Async reset mid-RELEASE (idx = 1).
        asyncrst_n = 1'b0;
        #2 asyncrst_n = 1'b1;
        ecnt = 0;
        goto_edge(27);
        chk("mid_release", {rst_n_out, rst_done, busy}, 6'b0011_01);
        #2 asyncrst_n = 1'b0;
        #1 chk("async_mid", {rst_n_out, rst_done, busy}, 6'b0000_01);
        #1 asyncrst_n = 1'b1;
        ecnt = 0;
        run_table("resync", 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
